// File: rtl/paddle_pkg.sv
// Shared direction/state encodings for the paddle button path and the paddle position block.
// Command and state codes are identical so a state can be driven straight onto btn/dir.
package paddle_pkg;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_POS  = 2'b01,
    ST_NEG  = 2'b10,
    ST_BOTH = 2'b11
  } btn_state_t;

  // Up maps to NEG (decrease y), down maps to POS (increase y).
  function automatic btn_state_t pair_to_state(input logic up, input logic dn);
    return btn_state_t'({up, dn});
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce counter for one raw button.
// Latency: a level stable from edge k is accepted at edge k+1+DEBOUNCE_CYCLES; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    // Any cycle agreeing with the accepted level restarts the stability count.
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/paddle_btn_encoder.sv
// Raw up/down buttons to one-cycle paddle step commands; outputs one cycle after debounced level, no backpressure.
// Build option PADDLE_BTN_AUTOREPEAT_EN: repeat steps every REPEAT_CYCLES while a direction is held.
module paddle_btn_encoder
  import paddle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 833333,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_raw,
  input  logic       btn_dn_raw,
  output logic [1:0] btn,
  output logic [1:0] dir
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cycles
    $error("paddle_btn_encoder: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 31 || (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)
      || (REPEAT_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_width
    $error("paddle_btn_encoder: CNT_W too narrow for the cycle counts");
  end

  logic db_up, db_dn;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_up_raw),
    .btn_db  (db_up)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_dn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_dn_raw),
    .btn_db  (db_dn)
  );

  btn_state_t state_q, state_d;
  logic [1:0] btn_q, btn_d;
  logic [1:0] dir_q, dir_d;
  logic       step;

`ifdef PADDLE_BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RCNT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
`endif

  always_comb begin
    state_d = pair_to_state(db_up, db_dn);
    btn_d   = DIR_NONE;
    dir_d   = DIR_NONE;
    step    = 1'b0;
`ifdef PADDLE_BTN_AUTOREPEAT_EN
    rcnt_d  = '0;
`endif
    case (state_d)
      ST_POS, ST_NEG: begin
        dir_d = state_d;
        // A change of state, including a direct POS/NEG swap, is an entry.
        if (state_q != state_d) begin
          step = 1'b1;
`ifdef PADDLE_BTN_AUTOREPEAT_EN
        end else if (rcnt_q == RCNT_LAST) begin
          step = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
`endif
        end
      end
      default: ;
    endcase
    if (step) begin
      btn_d = state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q  <= DIR_NONE;
      dir_q  <= DIR_NONE;
`ifdef PADDLE_BTN_AUTOREPEAT_EN
      rcnt_q <= '0;
`endif
    end else begin
      btn_q  <= btn_d;
      dir_q  <= dir_d;
`ifdef PADDLE_BTN_AUTOREPEAT_EN
      rcnt_q <= rcnt_d;
`endif
    end
  end

  assign btn = btn_q;
  assign dir = dir_q;

endmodule

// File: tb/tb_paddle_btn_encoder.sv
// Randomized plus directed bench for paddle_btn_encoder against a timestamp-based reference model.
module tb_paddle_btn_encoder;

  localparam int D = 4;
  localparam int R = 8;
  localparam int N = 4096;

`ifdef PADDLE_BTN_AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up_raw;
  logic       btn_dn_raw;
  logic [1:0] btn;
  logic [1:0] dir;

  always #5 clk = ~clk;

  paddle_btn_encoder #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up_raw (btn_up_raw),
    .btn_dn_raw (btn_dn_raw),
    .btn        (btn),
    .dir        (dir)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Input history indexed by clock edge number; index 0 = up, 1 = down.
  bit raw_h [0:1][0:N-1];
  bit rst_h [0:N-1];
  int cyc = 0;

  bit       m_db [0:1];
  bit [1:0] m_state;
  bit [1:0] m_btn;
  bit [1:0] m_dir;
  int       m_entry;

  // Level the debouncer compares at edge t: the raw sample two edges earlier, zeroed by reset.
  function automatic bit synced_at(input int b, input int t);
    if (t < 2) return 1'b0;
    if (rst_h[t-1] || rst_h[t-2]) return 1'b0;
    return raw_h[b][t-2];
  endfunction

  // Accept the opposite level once D consecutive non-reset edges all saw it.
  function automatic bit db_after(input int b, input int t, input bit cur);
    if (rst_h[t]) return 1'b0;
    for (int j = 0; j < D; j++) begin
      if (t - j < 0) return cur;
      if (rst_h[t-j] || synced_at(b, t - j) == cur) return cur;
    end
    return !cur;
  endfunction

  task automatic model_edge(input int t);
    bit [1:0] s;
    s = {m_db[0], m_db[1]};
    m_btn = 2'b00;
    m_dir = 2'b00;
    if (rst_h[t]) begin
      m_state = 2'b00;
    end else begin
      if (s == 2'b01 || s == 2'b10) begin
        m_dir = s;
        if (m_state != s) begin
          m_btn   = s;
          m_entry = t;
        end else if (AUTOREP && ((t - m_entry) % R == 0)) begin
          m_btn = s;
        end
      end
      m_state = s;
    end
    m_db[0] = db_after(0, t, m_db[0]);
    m_db[1] = db_after(1, t, m_db[1]);
  endtask

  task automatic tick(input bit r, input bit u, input bit d);
    if (cyc >= N) begin
      $display("FAIL cycle_budget: got %0d cycles expected fewer than %0d", cyc, N);
      $fatal(1, "cycle budget exhausted");
    end
    rst        = r;
    btn_up_raw = u;
    btn_dn_raw = d;
    rst_h[cyc]    = r;
    raw_h[0][cyc] = u;
    raw_h[1][cyc] = d;
    @(posedge clk);
    model_edge(cyc);
    #1;
    check_eq("btn", {30'd0, btn}, {30'd0, m_btn});
    check_eq("dir", {30'd0, dir}, {30'd0, m_dir});
    cyc++;
  endtask

  // Hold a pattern for n cycles; report first index and count of pulses equal to code.
  task automatic hold(input int n, input bit u, input bit d, input bit [1:0] code,
                      output int first, output int pulses);
    first  = -1;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, u, d);
      if (btn == code) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    int first, pulses, nz;
    m_db[0] = 1'b0; m_db[1] = 1'b0;
    m_state = 2'b00; m_entry = 0;

    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      check_eq("rst_btn", {30'd0, btn}, 32'd0);
      check_eq("rst_dir", {30'd0, dir}, 32'd0);
    end
    hold(10, 1'b1, 1'b0, 2'b10, first, pulses);
    check_eq("rst_first_step", first, 6);
    hold(12, 1'b0, 1'b0, 2'b10, first, pulses);

    hold(31, 1'b0, 1'b1, 2'b01, first, pulses);
    check_eq("press_first", first, 6);
    check_eq("press_pulses", pulses, AUTOREP ? 4 : 1);
    hold(12, 1'b0, 1'b0, 2'b01, first, pulses);
    check_eq("release_pulses", pulses, 0);

    hold(40, 1'b0, 1'b1, 2'b01, first, pulses);
    check_eq("hold40_pulses", pulses, AUTOREP ? 5 : 1);
    hold(12, 1'b0, 1'b0, 2'b01, first, pulses);
    hold(20, 1'b0, 1'b1, 2'b01, first, pulses);
    check_eq("repress_pulses", pulses, AUTOREP ? 2 : 1);
    hold(12, 1'b0, 1'b0, 2'b01, first, pulses);

    nz = 0;
    for (int rep = 0; rep < 5; rep++) begin
      for (int i = 0; i < 6; i++) begin
        tick(1'b0, (i < 3), 1'b0);
        if (btn != 2'b00 || dir != 2'b00) nz++;
      end
    end
    check_eq("bounce_quiet", nz, 0);
    hold(10, 1'b1, 1'b0, 2'b10, first, pulses);
    check_eq("bounce_first", first, 6);

    hold(10, 1'b1, 1'b0, 2'b10, first, pulses);
    hold(12, 1'b1, 1'b1, 2'b10, first, pulses);
    check_eq("both_btn", {30'd0, btn}, 32'd0);
    check_eq("both_dir", {30'd0, dir}, 32'd0);
    hold(20, 1'b0, 1'b1, 2'b01, first, pulses);
    check_eq("conflict_first", first, 6);
    check_eq("conflict_pulses", pulses, AUTOREP ? 2 : 1);

    tick(1'b1, 1'b0, 1'b1);
    check_eq("midrst_btn", {30'd0, btn}, 32'd0);
    check_eq("midrst_dir", {30'd0, dir}, 32'd0);
    hold(12, 1'b0, 1'b1, 2'b01, first, pulses);
    check_eq("midrst_first", first, 6);
    hold(12, 1'b0, 1'b0, 2'b01, first, pulses);

    for (int seg = 0; seg < 250; seg++) begin
      int  len;
      bit  u, d;
      len = $urandom_range(1, 12);
      u   = 1'($urandom_range(0, 1));
      d   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) tick(1'b1, u, d);
      for (int i = 0; i < len; i++) tick(1'b0, u, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
